// File: rtl/apb_master_arbiter_ctrl.sv
// Round-robin arbiter that shares one APB4 master port between NUM_REQ requesters.
// It runs the IDLE/SETUP/ACCESS sequence, decodes PSEL from PADDR and bounds PREADY wait states.
module apb_master_arbiter_ctrl #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NO_OF_SLAVES = 4,
    parameter int SLV_SEL_LSB  = 28,
    parameter int TIMEOUT      = 16
) (
    input  logic                               pclk,
    input  logic                               preset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    req_strb,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_slverr,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy,
    output logic [NO_OF_SLAVES-1:0]            psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [ADDR_WIDTH-1:0]              paddr,
    output logic [DATA_WIDTH-1:0]              pwdata,
    output logic [DATA_WIDTH/8-1:0]            pstrb,
    output logic [2:0]                         pprot,
    input  logic                               pready,
    input  logic [DATA_WIDTH-1:0]              prdata,
    input  logic                               pslverr
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int SB = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] last_grant, win;
    logic          any;
    logic [CW-1:0] cnt;
    logic          timed_out;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        int idx;
        logic [GW-1:0] ix;
        idx = 0;
        ix  = '0;
        any = 1'b0;
        win = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            ix = GW'(idx);
            if (!any && req_valid[ix]) begin
                any = 1'b1;
                win = ix;
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (state == ACCESS) && !pready && ((cnt + 1'b1) == TO_V);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = SETUP;
                    // Gated by reset so every output reads 0 while reset is held.
                    if (preset_n) req_ready = NUM_REQ'(1) << win;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant_id   <= '0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            cnt        <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        last_grant <= win;
                        grant_id   <= win;
                        pwrite     <= req_write[win];
                        paddr      <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        pwdata     <= req_write[win] ? req_wdata[win*DATA_WIDTH +: DATA_WIDTH] : '0;
                        pstrb      <= req_write[win] ? req_strb[win*SB +: SB] : '0;
                        cnt        <= '0;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid  <= NUM_REQ'(1) << grant_id;
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        rsp_slverr <= pslverr;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timed_out) begin
                            rsp_valid  <= NUM_REQ'(1) << grant_id;
                            rsp_rdata  <= '0;
                            rsp_slverr <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign penable = (state == ACCESS);
    assign psel    = busy ? (NO_OF_SLAVES'(1) << paddr[SLV_SEL_LSB +: SW]) : '0;
    assign pprot   = 3'b000;

endmodule

// File: tb/tb_apb_master_arbiter_ctrl.sv
// Scoreboard bench for apb_master_arbiter_ctrl: expected responses are queued at grant time
// and matched against rsp_valid; a simple slave model answers with a configurable wait count.
module tb_apb_master_arbiter_ctrl;
    localparam int NR = 4, AW = 32, DW = 32, NS = 4, TO = 16;

    logic               pclk = 1'b0, preset_n = 1'b0;
    logic [NR-1:0]      req_valid = '0, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR*DW/8-1:0] req_strb;
    logic [DW-1:0]      rsp_rdata, pwdata, prdata;
    logic               rsp_slverr, busy, penable, pwrite, pslverr = 1'b0, pready = 1'b0;
    logic [1:0]         grant_id;
    logic [NS-1:0]      psel;
    logic [AW-1:0]      paddr;
    logic [DW/8-1:0]    pstrb;
    logic [2:0]         pprot;

    logic          rq_write [NR];
    logic [AW-1:0] rq_addr  [NR];
    logic [DW-1:0] rq_wdata [NR];
    logic [3:0]    rq_strb  [NR];

    int            wait_cfg = 0;
    logic          err_cfg  = 1'b0;
    logic [DW-1:0] rd_cfg   = '0;

    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   total = 0, bad = 0, cyc = 0, acc_n = 0, acc_seen = 0;
    logic [NR-1:0] prev_rdy = '0;

    always #5 pclk = ~pclk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_write[i]             = rq_write[i];
            req_addr[i*AW +: AW]     = rq_addr[i];
            req_wdata[i*DW +: DW]    = rq_wdata[i];
            req_strb[i*4 +: 4]       = rq_strb[i];
        end
    end
    assign prdata = rd_cfg;

    apb_master_arbiter_ctrl #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .NO_OF_SLAVES(NS), .SLV_SEL_LSB(28), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset_n(preset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .grant_id(grant_id), .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor, scoreboard and slave model, all sampled away from the rising edge.
    always @(negedge pclk) begin
        cyc++;
        if (!preset_n) begin
            acc_n    = 0;
            pready   = 1'b0;
            pslverr  = 1'b0;
            prev_rdy = '0;
        end else begin
            if (rsp_valid != 0) begin
                if (sb.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_valid), 64'(1 << e.id));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_slverr", 64'(rsp_slverr), 64'(e.err));
                    chk("rsp_latency", 64'(cyc - e.cyc), 64'(e.lat));
                    chk("rsp_psel_pen", {psel, penable}, 0);
                end
            end
            if (req_ready != 0) begin
                exp_t e;
                int id;
                bit to;
                id = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) id = i;
                chk("rdy_onehot", 64'($onehot(req_ready)), 1);
                chk("rdy_width", 64'(prev_rdy), 0);
                grants.push_back(id);
                to      = (wait_cfg >= TO);
                e.id    = id;
                e.rdata = (to || rq_write[id]) ? '0 : rd_cfg;
                e.err   = to ? 1'b1 : err_cfg;
                e.cyc   = cyc;
                e.lat   = 3 + (to ? TO - 1 : wait_cfg);
                sb.push_back(e);
            end
            prev_rdy = req_ready;
            if (psel != 0 && penable) begin
                pready  = (acc_n >= wait_cfg);
                pslverr = pready & err_cfg;
                acc_n++;
                acc_seen++;
            end else begin
                acc_n   = 0;
                pready  = 1'b0;
                pslverr = 1'b0;
            end
        end
    end

    task automatic set_req(input int i, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        rq_write[i] = w; rq_addr[i] = a; rq_wdata[i] = d; rq_strb[i] = s;
    endtask

    // Raise req_valid[i], hold it until granted, then drop it; returns in the SETUP cycle.
    task automatic issue(input int i);
        bit got;
        got = 0;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge pclk);
            if (req_ready[i]) got = 1;
        end
        if (!got) chk("grant_timeout", 0, 1);
        @(posedge pclk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'(sb.size()), 0);
        @(posedge pclk); #1;
    endtask

    task automatic wait_grants(input int cnt_want);
        int n;
        n = 0;
        while (grants.size() < cnt_want && n < 100) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 100) chk("grants_timeout", 64'(grants.size()), 64'(cnt_want));
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        sb.delete();
        grants.delete();
        preset_n = 1'b1;
        @(posedge pclk); #1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0);
        #1;
        req_valid = 4'b1111;
        #3;
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_outputs", {busy, psel, penable, pwrite, rsp_valid, rsp_slverr, grant_id}, 0);
        chk("rst_paddr_pwdata", {paddr, pwdata}, 0);
        req_valid = '0;
        do_reset();

        // Single write from requester 0, no wait states.
        set_req(0, 1'b1, 32'h1000_0004, 32'hA5A5_5A5A, 4'hF);
        wait_cfg = 0; err_cfg = 1'b0;
        issue(0);
        chk("t1_setup_psel", {psel, penable}, {4'b0010, 1'b0});
        chk("t1_setup_bus", {pwrite, paddr, pwdata, 4'(pstrb)}, {1'b1, 32'h1000_0004, 32'hA5A5_5A5A, 4'hF});
        chk("t1_grant_busy", {grant_id, busy}, {2'd0, 1'b1});
        @(posedge pclk); #1;
        chk("t1_access", {psel, penable, pprot}, {4'b0010, 1'b1, 3'b000});
        drain();

        // Read from requester 2 with three wait states; write data must not leak to the bus.
        set_req(2, 1'b0, 32'h3000_0000, 32'h1234_5678, 4'hF);
        wait_cfg = 3; rd_cfg = 32'hDEAD_BEEF; acc_seen = 0;
        issue(2);
        chk("t2_setup", {psel, pwrite, pwdata, 4'(pstrb)}, {4'b1000, 1'b0, 32'h0, 4'h0});
        chk("t2_grant", 64'(grant_id), 2);
        drain();
        chk("t2_access_cycles", 64'(acc_seen), 4);

        // Round robin from reset with every requester valid.
        do_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, (i % 2) == 0, 32'(i) << 28 | 32'(i * 4), 32'h100 + 32'(i), 4'hF);
        wait_cfg = 0; rd_cfg = 32'h0BAD_F00D;
        req_valid = 4'b1111;
        wait_grants(5);
        @(posedge pclk); #1;
        req_valid = '0;
        drain();
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k), 64'(grants[k]), 64'(k % NR));

        // Wait states one short of the limit complete normally.
        set_req(1, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
        wait_cfg = TO - 1; rd_cfg = 32'h5555_AAAA; acc_seen = 0;
        issue(1);
        drain();
        chk("t_edge_access_cycles", 64'(acc_seen), 64'(TO));

        // Slave never ready: timeout after exactly TO ACCESS cycles.
        wait_cfg = 1000; rd_cfg = 32'hFFFF_0000; acc_seen = 0;
        issue(1);
        drain();
        chk("t4_access_cycles", 64'(acc_seen), 64'(TO));

        // Slave error, then a normal transfer is still granted.
        set_req(3, 1'b1, 32'h0000_0008, 32'hCAFE_0001, 4'h3);
        wait_cfg = 1; err_cfg = 1'b1;
        issue(3);
        chk("t5_setup_psel", 64'(psel), 64'(4'b0001));
        drain();
        err_cfg = 1'b0; wait_cfg = 0; rd_cfg = 32'h1357_9BDF;
        set_req(0, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
        issue(0);
        drain();

        // Reset in the middle of ACCESS abandons the transfer.
        wait_cfg = 1000;
        issue(1);
        @(posedge pclk); #2;
        chk("t6_in_access", {busy, penable}, 2'b11);
        preset_n = 1'b0;
        #1;
        chk("t6_async_clear", {busy, psel, penable, pwrite, rsp_valid, rsp_slverr, grant_id}, 0);
        chk("t6_async_bus", {paddr, pwdata, 4'(pstrb)}, 0);
        sb.delete();
        grants.delete();
        wait_cfg = 0;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;
        chk("t6_idle_after", 64'(busy), 0);
        req_valid = 4'b1001;
        wait_grants(1);
        chk("t6_first_winner", 64'(grants[0]), 0);
        @(posedge pclk); #1;
        req_valid = 4'b1000;
        wait_grants(2);
        @(posedge pclk); #1;
        req_valid = '0;
        drain();
        chk("t6_second_winner", 64'(grants[1]), 3);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/apb_master_arbiter_ctrl.md
Name: apb_master_arbiter_ctrl

Overview:
Shares one APB master port between NUM_REQ local requesters. Arbitrates round-robin, sequences the APB4 IDLE/SETUP/ACCESS protocol, decodes PSEL, and enforces a PREADY timeout. It sits between the testbench or subsystem request sources and apb_if, driving the signals the slave agent BFMs sample.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width (8, 16 or 32)
NO_OF_SLAVES, 4, number of PSEL lines (power of two)
SLV_SEL_LSB, 28, LSB of the PADDR field that selects the slave
TIMEOUT, 16, maximum ACCESS cycles with PREADY low; 0 disables the timeout

Ports:
pclk  in  1  APB clock; all logic is on the rising edge
preset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester transfer request
req_ready  out  NUM_REQ  one-hot acceptance pulse
req_write  in  NUM_REQ  1 = write
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_strb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid
rsp_slverr  out  1  error flag, valid with rsp_valid
grant_id  out  $clog2(NUM_REQ)  index of the current or last owner
busy  out  1  high in SETUP and ACCESS
psel  out  NO_OF_SLAVES  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB4 strobes
pprot  out  3  tied to 3'b000
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Reset: preset_n low clears all outputs to 0 immediately (asynchronous) and sets state = IDLE, last_grant = NUM_REQ-1, timeout counter = 0. A reset during SETUP or ACCESS abandons the transfer; no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is high, select a winner by round-robin. Search starts at (last_grant+1) mod NUM_REQ.
  - In the same cycle, req_ready[winner] = 1 (combinational from req_valid and state). req_ready is 0 in all other states.
  - On that edge, register pwrite, paddr, pwdata and pstrb from the winner's inputs, update last_grant and grant_id, and go to SETUP.
  - For reads, pstrb = 0 and pwdata = 0.
- SETUP: psel[paddr[SLV_SEL_LSB +: $clog2(NO_OF_SLAVES)]] = 1, penable = 0; go to ACCESS unconditionally.
- ACCESS: psel held, penable = 1; paddr, pwrite, pwdata and pstrb are stable throughout.
  - pready = 1: capture prdata (reads only; writes return 0) and pslverr. Go to IDLE. Next cycle: rsp_valid[grant_id] = 1 for exactly one cycle, with rsp_rdata and rsp_slverr; psel and penable are 0.
  - pready = 0: increment the counter. If TIMEOUT != 0 and the counter reaches TIMEOUT, go to IDLE and respond with rsp_slverr = 1 and rsp_rdata = 0.
  - The counter clears on entry to SETUP.
- Latency: req_ready to SETUP is 1 cycle; minimum request-accept to rsp_valid is 3 cycles. An IDLE cycle always separates transfers (no back-to-back SETUP), so peak throughput is one transfer per 3 cycles.
- rsp_valid and a new req_ready may be high in the same cycle, because IDLE follows ACCESS.
- A requester that drops req_valid before it is granted is simply skipped. Inputs are sampled only in the req_ready cycle.
- paddr and pwdata keep their last values in IDLE; psel = 0 there.
- busy = (state != IDLE).

Test Plan:
- Single write from requester 0, addr 0x1000_0004, data 0xA5A5_5A5A, strb 0xF, pready high on the first ACCESS cycle -> psel = 4'b0010, penable low then high, 3 cycles from req_ready to rsp_valid[0], rsp_slverr = 0.
- Read from requester 2, addr 0x3000_0000, pready low 3 cycles then high with prdata 0xDEAD_BEEF -> psel = 4'b1000, 4 ACCESS cycles, pstrb = 0, rsp_valid[2] with rsp_rdata 0xDEAD_BEEF.
- All 4 requesters continuously valid from reset -> grant order 0, 1, 2, 3, 0; each req_ready pulse is one cycle wide and one-hot.
- Slave holds pready low, TIMEOUT = 16 -> exactly 16 ACCESS cycles, then psel and penable drop and rsp_slverr = 1, rsp_rdata = 0.
- Write with pslverr = 1 on completion -> rsp_slverr = 1, and the next request is still granted normally.
- preset_n asserted during ACCESS -> psel, penable and all other outputs go to 0 asynchronously, no rsp_valid; after release, requester 0 wins first.
